// File: rtl/serial_subtractor_with_loader_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_subtractor_with_loader_pkg;

  localparam int SIZE_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One extra bit so the counter can reach size without wrapping.
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_with_loader_if.sv
// Load/control/result bundle between a driver and the serial subtractor.
interface serial_subtractor_with_loader_if #(parameter int size = 16);
  logic [size-1:0] in;
  logic            ld_sel;
  logic            ld;
  logic            start;
  logic            en;
  logic            bin;
  logic            busy;
  logic            done;
  logic [size-1:0] diff;
  logic            bout;

  modport master (output in, ld_sel, ld, start, en, bin,
                  input  busy, done, diff, bout);
  modport slave  (input  in, ld_sel, ld, start, en, bin,
                  output busy, done, diff, bout);
endinterface

// File: rtl/serial_subtractor_with_loader_bit.sv
// One-bit full subtractor: d = a - b - bi, with borrow out.
module full_subtractor_bit (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);
endmodule

// File: rtl/serial_subtractor_with_loader.sv
// Bit-serial A - B - bin, LSB first, one bit per enabled cycle.
module serial_subtractor_with_loader
  import serial_subtractor_with_loader_pkg::*;
#(
  parameter int size = SIZE_DEFAULT
) (
  input logic clk,
  input logic rst,
  serial_subtractor_with_loader_if.slave bus
);
  localparam int CW = cnt_w(size);
  localparam logic [CW-1:0] LAST = CW'(size - 1);

  state_t          state;
  logic [size-1:0] a_reg, b_reg, a_sh, b_sh, diff_r;
  logic [CW-1:0]   cnt;
  logic            br, bout_r, busy_r, done_r;
  logic            d, bo;

  full_subtractor_bit u_bit (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .bi (br),
    .d  (d),
    .bo (bo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      diff_r <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      bout_r <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          // start wins over ld so the operands used are the pre-edge ones
          if (bus.start) begin
            br     <= bus.bin;
            cnt    <= '0;
            a_sh   <= a_reg;
            b_sh   <= b_reg;
            busy_r <= 1'b1;
            state  <= RUN;
          end else if (bus.ld) begin
            if (bus.ld_sel) b_reg <= bus.in;
            else            a_reg <= bus.in;
          end
        end
        RUN: begin
          if (bus.en) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            diff_r <= {d, diff_r[size-1:1]};
            br     <= bo;
            cnt    <= cnt + 1'b1;
            if (cnt == LAST) begin
              bout_r <= bo;
              busy_r <= 1'b0;
              done_r <= 1'b1;
              state  <= DONE;
            end
          end
        end
        DONE: begin
          done_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.diff = diff_r;
  assign bus.bout = bout_r;

endmodule

// File: tb/tb_serial_subtractor_with_loader.sv
// Directed vectors for the serial subtractor at size=16.
module tb_serial_subtractor_with_loader;
  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  serial_subtractor_with_loader_if #(.size(16)) bus ();

  serial_subtractor_with_loader #(.size(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic sel, input logic [15:0] val);
    bus.ld = 1'b1; bus.ld_sel = sel; bus.in = val;
    @(negedge clk);
    bus.ld = 1'b0;
  endtask

  // Optionally loads A/B, starts, then walks the run watching latency/busy.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic bi, input bit do_ld, input int stall_at,
                        input int stall_len, input bit inject, input bit ld_with_start,
                        input logic [15:0] exp_d, input logic exp_bo, input int exp_lat);
    int cnt;
    int busy_n;
    if (do_ld) begin
      load(1'b0, a);
      load(1'b1, b);
    end
    bus.bin = bi; bus.start = 1'b1;
    if (ld_with_start) begin
      bus.ld = 1'b1; bus.ld_sel = 1'b0; bus.in = 16'h0001;
    end
    @(negedge clk);
    bus.start = 1'b0; bus.ld = 1'b0;
    cnt = 0; busy_n = 0;
    while (!bus.done && cnt < 200) begin
      if (bus.busy) busy_n++;
      bus.en = !(cnt >= stall_at && cnt < stall_at + stall_len);
      if (inject && cnt == 2) begin
        bus.ld = 1'b1; bus.ld_sel = 1'b0; bus.in = 16'h0000; bus.start = 1'b1;
      end else begin
        bus.ld = 1'b0; bus.start = 1'b0;
      end
      @(negedge clk);
      cnt++;
    end
    bus.en = 1'b1; bus.ld = 1'b0; bus.start = 1'b0;
    chk({tag, "_lat"}, cnt, exp_lat);
    chk({tag, "_busy"}, busy_n, exp_lat);
    chk({tag, "_diff"}, bus.diff, exp_d);
    chk({tag, "_bout"}, bus.bout, exp_bo);
    @(negedge clk);
    chk({tag, "_pulse"}, bus.done, 1'b0);
    chk({tag, "_hold"}, {bus.bout, bus.diff}, {exp_bo, exp_d});
  endtask

  initial begin
    int cnt;
    int seen;
    rst = 1'b1;
    bus.in = '0; bus.ld_sel = 1'b0; bus.ld = 1'b0;
    bus.start = 1'b0; bus.en = 1'b1; bus.bin = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    chk("rst_state", {bus.busy, bus.done, bus.bout, bus.diff}, 19'h0);

    run_op("basic",  16'h1234, 16'h0234, 1'b0, 1'b1, 99, 0, 1'b0, 1'b0, 16'h1000, 1'b0, 16);
    run_op("under",  16'h0000, 16'h0001, 1'b0, 1'b1, 99, 0, 1'b0, 1'b0, 16'hFFFF, 1'b1, 16);
    run_op("bin",    16'h0005, 16'h0003, 1'b1, 1'b1, 99, 0, 1'b0, 1'b0, 16'h0001, 1'b0, 16);
    run_op("eq_bin", 16'h8000, 16'h8000, 1'b1, 1'b1, 99, 0, 1'b0, 1'b0, 16'hFFFF, 1'b1, 16);
    run_op("eq",     16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 99, 0, 1'b0, 1'b0, 16'h0000, 1'b0, 16);
    run_op("stall",  16'hFFFF, 16'h0F0F, 1'b0, 1'b1,  3, 5, 1'b0, 1'b0, 16'hF0F0, 1'b0, 21);
    // A/B stay FFFF/0F0F: ld alongside start and ld/start mid-run are dropped
    run_op("ldstart", 16'h0, 16'h0, 1'b0, 1'b0, 99, 0, 1'b0, 1'b1, 16'hF0F0, 1'b0, 16);
    run_op("inject",  16'h0, 16'h0, 1'b0, 1'b0, 99, 0, 1'b1, 1'b0, 16'hF0F0, 1'b0, 16);
    run_op("reuse",   16'h0, 16'h0, 1'b0, 1'b0, 99, 0, 1'b0, 1'b0, 16'hF0F0, 1'b0, 16);

    // Abort mid-run with reset
    load(1'b0, 16'h1234);
    load(1'b1, 16'h0001);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) @(negedge clk);
    chk("pre_rst_busy", bus.busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_state", {bus.busy, bus.done, bus.bout, bus.diff}, 19'h0);
    seen = 0;
    for (cnt = 0; cnt < 25; cnt++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen++;
    end
    chk("abort_quiet", seen, 0);
    // Reset cleared A and B too
    run_op("post_rst", 16'h0, 16'h0, 1'b1, 1'b0, 99, 0, 1'b0, 1'b0, 16'hFFFF, 1'b1, 16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
